// File: rtl/cikis_paketleyici.sv
`default_nettype none
// ============================================================================
// Module   : cikis_paketleyici
// Purpose  : Packs 8-bit pixels into 32-bit words and queues them in a FIFO
//            for a valid/ready consumer. Optional feature macro:
//            PAKETLEYICI_TASMA_SAYACI_EN (saturating dropped-word counter).
// Revision : 1.0 - initial release
// ============================================================================
module cikis_paketleyici #(
  parameter int GENISLIK      = 320,
  parameter int YUKSEKLIK     = 240,
  parameter int FIFO_DERINLIK = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        veri_etkin_i,
  input  logic [7:0]  veri_i,
  output logic        paket_gecerli_o,
  input  logic        paket_hazir_i,
  output logic [31:0] paket_o,
  output logic        paket_son_o,
  output logic        tasma_o,
  output logic [15:0] tasma_sayisi_o
);

  localparam int              c_AW         = (FIFO_DERINLIK > 1) ? $clog2(FIFO_DERINLIK) : 1;
  localparam logic [16:0]     c_SON_PIKSEL = 17'(GENISLIK * YUKSEKLIK - 1);
  localparam logic [c_AW:0]   c_DERINLIK   = (c_AW + 1)'(FIFO_DERINLIK);

  logic [16:0]     r_piksel_sayac;
  logic [23:0]     r_birikim;
  logic [32:0]     r_bellek [FIFO_DERINLIK];
  logic [c_AW-1:0] r_yaz_ptr;
  logic [c_AW-1:0] r_oku_ptr;
  logic [c_AW:0]   r_doluluk;
  logic            r_tasma;

  logic [1:0]  w_bayt;
  logic        w_son_piksel;
  logic [31:0] w_kelime;
  logic        w_push_istek;
  logic        w_dolu;
  logic        w_bos;
  logic        w_pop;
  logic        w_push;
  logic        w_dusur;
  logic [32:0] w_cikis;

  assign w_bayt       = r_piksel_sayac[1:0];
  assign w_son_piksel = (r_piksel_sayac == c_SON_PIKSEL);

  // Current partial word with the incoming pixel merged into its byte lane
  always_comb begin
    w_kelime = {8'h00, r_birikim};
    case (w_bayt)
      2'd0:    w_kelime[7:0]   = veri_i;
      2'd1:    w_kelime[15:8]  = veri_i;
      2'd2:    w_kelime[23:16] = veri_i;
      default: w_kelime[31:24] = veri_i;
    endcase
  end

  // A frame whose size is not a multiple of 4 still flushes its tail word
  assign w_push_istek = veri_etkin_i && ((w_bayt == 2'd3) || w_son_piksel);
  assign w_dolu       = (r_doluluk == c_DERINLIK);
  assign w_bos        = (r_doluluk == '0);
  assign w_pop        = !w_bos && paket_hazir_i;
  assign w_push       = w_push_istek && (!w_dolu || w_pop);
  assign w_dusur      = w_push_istek && w_dolu && !w_pop;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_piksel_sayac <= '0;
      r_birikim      <= '0;
    end else if (veri_etkin_i) begin
      r_piksel_sayac <= w_son_piksel ? 17'd0 : r_piksel_sayac + 17'd1;
      r_birikim      <= w_push_istek ? 24'h0 : w_kelime[23:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_bellek[r_yaz_ptr] <= {w_son_piksel, w_kelime};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_yaz_ptr <= '0;
      r_oku_ptr <= '0;
      r_doluluk <= '0;
      r_tasma   <= 1'b0;
    end else begin
      if (w_push) r_yaz_ptr <= r_yaz_ptr + 1'b1;
      if (w_pop)  r_oku_ptr <= r_oku_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_doluluk <= r_doluluk + 1'b1;
        2'b01:   r_doluluk <= r_doluluk - 1'b1;
        default: r_doluluk <= r_doluluk;
      endcase
      if (w_dusur) r_tasma <= 1'b1;
    end
  end

  // Outputs are forced to zero while empty so stale memory never shows
  assign w_cikis         = r_bellek[r_oku_ptr];
  assign paket_gecerli_o = !w_bos;
  assign paket_o         = w_bos ? 32'h0 : w_cikis[31:0];
  assign paket_son_o     = !w_bos && w_cikis[32];
  assign tasma_o         = r_tasma;

`ifdef PAKETLEYICI_TASMA_SAYACI_EN
  logic [15:0] r_tasma_sayisi;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_tasma_sayisi <= '0;
    end else if (w_dusur && (r_tasma_sayisi != 16'hFFFF)) begin
      r_tasma_sayisi <= r_tasma_sayisi + 16'd1;
    end
  end

  assign tasma_sayisi_o = r_tasma_sayisi;
`else
  assign tasma_sayisi_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cikis_paketleyici.sv
`default_nettype none
// ============================================================================
// Module   : tb_cikis_paketleyici
// Purpose  : Self-checking bench for cikis_paketleyici against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cikis_paketleyici;

  localparam int GEN = 320;
  localparam int YUK = 240;
  localparam int DER = 8;
  localparam int TOPLAM = GEN * YUK;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        veri_etkin_i = 1'b0;
  logic [7:0]  veri_i = 8'h00;
  logic        paket_gecerli_o;
  logic        paket_hazir_i = 1'b0;
  logic [31:0] paket_o;
  logic        paket_son_o;
  logic        tasma_o;
  logic [15:0] tasma_sayisi_o;

  int n_checks = 0;
  int n_fail = 0;

  cikis_paketleyici #(
    .GENISLIK(GEN), .YUKSEKLIK(YUK), .FIFO_DERINLIK(DER)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .veri_etkin_i(veri_etkin_i), .veri_i(veri_i),
    .paket_gecerli_o(paket_gecerli_o), .paket_hazir_i(paket_hazir_i),
    .paket_o(paket_o), .paket_son_o(paket_son_o),
    .tasma_o(tasma_o), .tasma_sayisi_o(tasma_sayisi_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: pixel stream -> words -> bounded queue of DER entries
  logic [32:0] mq[$];
  int          mk = 0;
  logic [31:0] mpart = 32'h0;
  bit          mtasma = 1'b0;
  int          mdrop = 0;
  bit          m_pop, m_push;
  logic [32:0] m_w;

  always @(posedge clk_i) begin
    if (!rstn_i) begin
      mq.delete();
      mk = 0; mpart = 32'h0; mtasma = 1'b0; mdrop = 0;
    end else begin
      m_pop = (mq.size() > 0) && paket_hazir_i;
      m_push = 1'b0;
      m_w = '0;
      if (veri_etkin_i) begin
        mpart[8*(mk%4) +: 8] = veri_i;
        if (mk % 4 == 3) begin
          m_push = 1'b1;
          m_w = {(mk == TOPLAM - 1), mpart};
          mpart = 32'h0;
        end
        mk = (mk + 1) % TOPLAM;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DER) mq.push_back(m_w);
        else begin mtasma = 1'b1; mdrop++; end
      end
    end
  end

  function automatic logic [15:0] exp_sayisi(input int drops);
`ifdef PAKETLEYICI_TASMA_SAYACI_EN
    return (drops > 65535) ? 16'hFFFF : 16'(drops);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b0; veri_etkin_i = 1'b0; paket_hazir_i = 1'b0; veri_i = 8'h00;
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rstn_i = 1'b0; veri_etkin_i = 1'b1; veri_i = 8'($urandom); paket_hazir_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_checks++; if (paket_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL reset_gecerli: got %b expected 0", paket_gecerli_o); end
    n_checks++; if (paket_o !== 32'h0) begin n_fail++; $display("FAIL reset_paket: got %h expected 0", paket_o); end
    n_checks++; if (paket_son_o !== 1'b0) begin n_fail++; $display("FAIL reset_son: got %b expected 0", paket_son_o); end
    n_checks++; if (tasma_o !== 1'b0) begin n_fail++; $display("FAIL reset_tasma: got %b expected 0", tasma_o); end
    n_checks++; if (tasma_sayisi_o !== 16'h0) begin n_fail++; $display("FAIL reset_sayisi: got %h expected 0", tasma_sayisi_o); end
    rstn_i = 1'b1; veri_etkin_i = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    paket_hazir_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      veri_etkin_i = (i < 4);
      veri_i = 8'(i + 1);
      @(negedge clk_i);
      n_checks++;
      if (paket_gecerli_o !== (i == 3)) begin n_fail++; $display("FAIL basic_gecerli[%0d]: got %b expected %b", i, paket_gecerli_o, (i == 3)); end
      if (i == 3) begin
        n_checks++; if (paket_o !== 32'h04030201) begin n_fail++; $display("FAIL basic_paket: got %h expected 04030201", paket_o); end
        n_checks++; if (paket_son_o !== 1'b0) begin n_fail++; $display("FAIL basic_son: got %b expected 0", paket_son_o); end
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] px [4];
    px[0] = 8'h11; px[1] = 8'h22; px[2] = 8'h33; px[3] = 8'h44;
    do_reset();
    paket_hazir_i = 1'b1;
    veri_etkin_i = 1'b1; veri_i = 8'hAA; @(negedge clk_i);
    veri_i = 8'hBB; @(negedge clk_i);
    rstn_i = 1'b0; veri_i = 8'($urandom);
    @(negedge clk_i);
    n_checks++; if (paket_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_gecerli: got %b expected 0", paket_gecerli_o); end
    n_checks++; if (paket_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_paket: got %h expected 0", paket_o); end
    n_checks++; if (tasma_o !== 1'b0 || tasma_sayisi_o !== 16'h0 || paket_son_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_flags: got tasma=%b sayisi=%h son=%b expected all 0", tasma_o, tasma_sayisi_o, paket_son_o); end
    rstn_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      veri_i = px[i];
      @(negedge clk_i);
      n_checks++;
      if (paket_gecerli_o !== (i == 3)) begin n_fail++; $display("FAIL mid_rst_gecerli[%0d]: got %b expected %b", i, paket_gecerli_o, (i == 3)); end
    end
    veri_etkin_i = 1'b0;
    n_checks++; if (paket_o !== 32'h44332211) begin n_fail++; $display("FAIL mid_rst_word: got %h expected 44332211", paket_o); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_w [10];
    do_reset();
    paket_hazir_i = 1'b0;
    for (int p = 0; p < 40; p++) begin
      veri_etkin_i = 1'b1;
      veri_i = 8'($urandom);
      exp_w[p/4][8*(p%4) +: 8] = veri_i;
      @(negedge clk_i);
    end
    veri_etkin_i = 1'b0;
    n_checks++; if (tasma_o !== 1'b1) begin n_fail++; $display("FAIL ovf_tasma: got %b expected 1", tasma_o); end
    n_checks++; if (tasma_sayisi_o !== exp_sayisi(2)) begin n_fail++; $display("FAIL ovf_sayisi: got %0d expected %0d", tasma_sayisi_o, exp_sayisi(2)); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (paket_gecerli_o !== 1'b1 || paket_o !== exp_w[0]) begin
        n_fail++; $display("FAIL ovf_hold[%0d]: got v=%b %h expected v=1 %h", c, paket_gecerli_o, paket_o, exp_w[0]); end
    end
    paket_hazir_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n_checks++;
      if (paket_gecerli_o !== 1'b1 || paket_o !== exp_w[j]) begin
        n_fail++; $display("FAIL ovf_drain[%0d]: got v=%b %h expected v=1 %h", j, paket_gecerli_o, paket_o, exp_w[j]); end
      @(negedge clk_i);
    end
    n_checks++; if (paket_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b expected 0", paket_gecerli_o); end
    n_checks++; if (tasma_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", tasma_o); end
  endtask

  task automatic test_full_simul();
    logic [31:0] exp_w [9];
    do_reset();
    paket_hazir_i = 1'b0;
    for (int p = 0; p < 36; p++) begin
      veri_etkin_i = 1'b1;
      veri_i = 8'($urandom);
      exp_w[p/4][8*(p%4) +: 8] = veri_i;
      paket_hazir_i = (p == 35);
      @(negedge clk_i);
    end
    veri_etkin_i = 1'b0; paket_hazir_i = 1'b0;
    n_checks++; if (tasma_o !== 1'b0) begin n_fail++; $display("FAIL full_tasma: got %b expected 0", tasma_o); end
    n_checks++; if (tasma_sayisi_o !== 16'h0) begin n_fail++; $display("FAIL full_sayisi: got %0d expected 0", tasma_sayisi_o); end
    @(negedge clk_i);
    paket_hazir_i = 1'b1;
    for (int j = 1; j < 9; j++) begin
      n_checks++;
      if (paket_gecerli_o !== 1'b1 || paket_o !== exp_w[j]) begin
        n_fail++; $display("FAIL full_drain[%0d]: got v=%b %h expected v=1 %h", j, paket_gecerli_o, paket_o, exp_w[j]); end
      @(negedge clk_i);
    end
    n_checks++; if (paket_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b expected 0", paket_gecerli_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      veri_etkin_i = ($urandom_range(0, 3) != 0);
      veri_i = 8'($urandom);
      paket_hazir_i = (c < 750) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      @(negedge clk_i);
      n_checks++;
      if (paket_gecerli_o !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_gecerli[%0d]: got %b expected %b", c, paket_gecerli_o, (mq.size() > 0)); end
      if (mq.size() > 0) begin
        n_checks++;
        if (paket_o !== mq[0][31:0] || paket_son_o !== mq[0][32]) begin
          n_fail++; $display("FAIL rnd_word[%0d]: got %h/%b expected %h/%b", c, paket_o, paket_son_o, mq[0][31:0], mq[0][32]); end
      end
      n_checks++;
      if (tasma_o !== mtasma || tasma_sayisi_o !== exp_sayisi(mdrop)) begin
        n_fail++; $display("FAIL rnd_tasma[%0d]: got %b/%0d expected %b/%0d", c, tasma_o, tasma_sayisi_o, mtasma, exp_sayisi(mdrop)); end
    end
    veri_etkin_i = 1'b0;
  endtask

  task automatic test_frame();
    int wc;
    int b;
    logic [31:0] exp;
    wc = 0;
    do_reset();
    paket_hazir_i = 1'b1;
    for (int k = 0; k < TOPLAM + 6; k++) begin
      veri_etkin_i = (k < TOPLAM + 4);
      veri_i = 8'(k % 256);
      @(negedge clk_i);
      if (paket_gecerli_o === 1'b1) begin
        b = (4 * wc) % 256;
        exp = {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
        n_checks++;
        if (paket_o !== exp) begin n_fail++; $display("FAIL frame_word[%0d]: got %h expected %h", wc, paket_o, exp); end
        n_checks++;
        if (paket_son_o !== (wc == TOPLAM / 4 - 1)) begin n_fail++; $display("FAIL frame_son[%0d]: got %b expected %b", wc, paket_son_o, (wc == TOPLAM / 4 - 1)); end
        wc++;
      end
    end
    n_checks++;
    if (wc !== TOPLAM / 4 + 1) begin n_fail++; $display("FAIL frame_count: got %0d expected %0d", wc, TOPLAM / 4 + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_midword();
    test_overflow();
    test_full_simul();
    test_random();
    test_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cikis_paketleyici.md
CIKIS_PAKETLEYICI -- requirements
Module: cikis_paketleyici

Interface
REQ-001 The block SHALL have parameter GENISLIK, default 320, the pixels per image line.
REQ-002 The block SHALL have parameter YUKSEKLIK, default 240, the lines per frame.
REQ-003 The block SHALL have parameter FIFO_DERINLIK, default 8, the 32-bit word FIFO depth (power of two, 2..64).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-005 The block SHALL have port rstn_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port veri_etkin_i, input, 1 bit: pixel valid, driven by the convolution unit's veri_etkin_o; it has no backpressure.
REQ-007 The block SHALL have port veri_i, input, 8 bits: pixel value.
REQ-008 The block SHALL have port paket_gecerli_o, output, 1 bit: output word valid.
REQ-009 The block SHALL have port paket_hazir_i, input, 1 bit: consumer ready.
REQ-010 The block SHALL have port paket_o, output, 32 bits: packed word.
REQ-011 The block SHALL have port paket_son_o, output, 1 bit: the current word is the last word of a frame.
REQ-012 The block SHALL have port tasma_o, output, 1 bit: sticky overflow flag.
REQ-013 The block SHALL have port tasma_sayisi_o, output, 16 bits: count of dropped words.

Function
REQ-014 Each accepted pixel (veri_etkin_i=1) SHALL be stored in byte (k mod 4) of the accumulator, where k is the pixel index within the frame; byte 0 is paket_o[7:0].
REQ-015 When veri_etkin_i=0, the accumulator and counters SHALL hold.
REQ-016 A 17-bit pixel counter SHALL run 0..GENISLIK*YUKSEKLIK-1 and wrap to 0 after the last pixel; it advances on every accepted pixel, including pixels of dropped words.
REQ-017 In the cycle the 4th pixel of a word is accepted, the completed word SHALL be pushed into the FIFO together with a son bit; son=1 only for the word containing pixel GENISLIK*YUKSEKLIK-1.
REQ-018 A word pushed in cycle N into an empty FIFO SHALL appear with paket_gecerli_o=1 in cycle N+1.
REQ-019 A pop SHALL occur when paket_gecerli_o=1 and paket_hazir_i=1.
REQ-020 While paket_gecerli_o=1 and paket_hazir_i=0, paket_o and paket_son_o SHALL hold stable.
REQ-021 paket_gecerli_o SHALL NOT depend combinationally on paket_hazir_i.
REQ-022 Words SHALL leave the FIFO in push order.
REQ-023 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-024 A push to a full FIFO without a simultaneous pop SHALL drop the word and set tasma_o=1 from the next cycle; only reset clears tasma_o.
REQ-025 A pop from an empty FIFO SHALL be impossible, since paket_gecerli_o=0 whenever the FIFO is empty.

Reset
REQ-026 While rstn_i=0 at a clock edge, the block SHALL set paket_gecerli_o=0, paket_o=0, paket_son_o=0, tasma_o=0 and tasma_sayisi_o=0.
REQ-027 While rstn_i=0 at a clock edge, the block SHALL clear the FIFO read and write pointers, the pixel counter and any partial word.
REQ-028 Reset asserted mid-word or mid-frame SHALL discard all buffered data; the first pixel after reset is pixel 0 of a new frame.

Configuration
REQ-029 With macro PAKETLEYICI_TASMA_SAYACI_EN defined, tasma_sayisi_o SHALL increment by 1 for each dropped word and saturate at 0xFFFF.
REQ-030 With PAKETLEYICI_TASMA_SAYACI_EN undefined, tasma_sayisi_o SHALL be constant 0, no counter register SHALL exist, and tasma_o behaviour SHALL be unchanged.

Verification
REQ-031 Pixels 0x01,0x02,0x03,0x04 on consecutive cycles with hazir=1 -> paket_o=0x04030201 with paket_gecerli_o=1 for one cycle, one cycle after the 4th pixel, paket_son_o=0.
REQ-032 Full 320x240 frame with veri_i=k mod 256 and hazir=1 -> 19200 words; paket_son_o=1 only on word 19199=0xFFFEFDFC; the next frame's first word is 0x03020100.
REQ-033 hazir=0 during 40 pixels (10 words), depth 8 -> 8 words held stable, 2 dropped; tasma_o=1 and tasma_sayisi_o=2 (0 with the macro undefined); raising hazir then drains the 8 words in order.
REQ-034 FIFO full, with hazir=1 in the same cycle as the 4th pixel of the 9th word -> no drop, tasma_o stays 0, FIFO remains full.
REQ-035 Pixels 0xAA,0xBB, then rstn_i=0 for one cycle, then 0x11,0x22,0x33,0x44 -> first output word 0x44332211, all outputs 0 during reset.
